// File: rtl/pw_seq_checker.sv
// pw_seq_checker: push-button password checker with entry timeout, failed-attempt counting and timed lockout.
// Define PW_PROG_EN to let pw_load/pw_new replace the stored code while the checker is open.
module pw_seq_checker #(
    parameter int NBTN        = 4,
    parameter int SEQ_LEN     = 4,
    localparam int IDW        = (NBTN > 1) ? $clog2(NBTN) : 1,
    parameter logic [SEQ_LEN*IDW-1:0] PW_DEFAULT = 8'hE4,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYC    = 1000,
    parameter int TIMEOUT_CYC = 500,
    localparam int FCW        = $clog2(MAX_FAIL + 1)
) (
    input  logic                   clkin,
    input  logic                   reset,
    input  logic [NBTN-1:0]        btn,
    input  logic                   clr,
    input  logic                   pw_load,
    input  logic [SEQ_LEN*IDW-1:0] pw_new,
    output logic                   pass_en,
    output logic                   fail_pulse,
    output logic                   locked,
    output logic [FCW-1:0]         fail_cnt
);

    localparam int CW   = SEQ_LEN * IDW;
    localparam int IDXW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam int TOW  = $clog2(TIMEOUT_CYC + 1);
    localparam int LKW  = $clog2(LOCK_CYC + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ENTRY, ST_OPEN, ST_LOCK} state_e;

    state_e          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            mismatch_q, mismatch_d;
    logic [FCW-1:0]  fail_cnt_q, fail_cnt_d;
    logic [TOW-1:0]  idle_q, idle_d;
    logic [LKW-1:0]  lock_q, lock_d;
    logic            fail_hit_q, fail_hit_d;
    logic [NBTN-1:0] btn_q, btn_d;

    logic            pass_en_q, pass_en_d;
    logic            locked_q, locked_d;
    logic            fail_pulse_q, fail_pulse_d;
    logic [FCW-1:0]  fail_cnt_out_q, fail_cnt_out_d;

    logic [CW-1:0]   code;

`ifdef PW_PROG_EN
    logic [CW-1:0]   code_q, code_d;

    always_comb begin
        code_d = code_q;
        if (state_q == ST_OPEN && pw_load) code_d = pw_new;
    end

    // NOTE: the code register sits on the async reset so a reset always restores PW_DEFAULT.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) code_q <= PW_DEFAULT;
        else       code_q <= code_d;
    end

    assign code = code_q;
`else
    logic unused_ok;
    assign unused_ok = &{1'b0, pw_load, pw_new};
    assign code      = PW_DEFAULT;
`endif

    // Press decode: one rising bit is a digit, several in the same cycle make one invalid digit.
    logic            press, multi, seen;
    logic [NBTN-1:0] rise;
    logic [IDW-1:0]  digit, want;
    logic [IDXW-1:0] cur_idx;
    logic            cur_mis;

    always_comb begin
        // NOTE: every comb output gets a default first, so no path leaves a latch behind.
        rise  = btn & ~btn_q;
        seen  = 1'b0;
        multi = 1'b0;
        digit = '0;
        for (int i = 0; i < NBTN; i++) begin
            if (rise[i]) begin
                if (seen) multi = 1'b1;
                seen  = 1'b1;
                digit = IDW'(i);
            end
        end
        press   = seen;
        cur_idx = (state_q == ST_ENTRY) ? idx_q : '0;
        want    = '0;
        for (int k = 0; k < SEQ_LEN; k++) begin
            if (cur_idx == IDXW'(k)) want = code[k*IDW +: IDW];
        end
        cur_mis = ((state_q == ST_ENTRY) && mismatch_q) || multi || (digit != want);
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        mismatch_d = mismatch_q;
        fail_cnt_d = fail_cnt_q;
        idle_d     = idle_q;
        lock_d     = lock_q;
        fail_hit_d = 1'b0;
        btn_d      = btn;
        unique case (state_q)
            ST_IDLE, ST_ENTRY: begin
                if (press) begin
                    idle_d = '0;
                    if (cur_idx == IDXW'(SEQ_LEN - 1)) begin
                        idx_d      = '0;
                        mismatch_d = 1'b0;
                        if (!cur_mis) begin
                            state_d    = ST_OPEN;
                            fail_cnt_d = '0;
                        end else begin
                            fail_hit_d = 1'b1;
                            fail_cnt_d = (fail_cnt_q == FCW'(MAX_FAIL)) ? fail_cnt_q
                                                                        : fail_cnt_q + FCW'(1);
                            if (fail_cnt_d == FCW'(MAX_FAIL)) begin
                                state_d = ST_LOCK;
                                lock_d  = '0;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                    end else begin
                        state_d    = ST_ENTRY;
                        idx_d      = cur_idx + IDXW'(1);
                        mismatch_d = cur_mis;
                    end
                end else if (state_q == ST_ENTRY) begin
                    if (idle_q == TOW'(TIMEOUT_CYC - 1)) begin
                        state_d    = ST_IDLE;
                        idx_d      = '0;
                        mismatch_d = 1'b0;
                        idle_d     = '0;
                    end else begin
                        idle_d = idle_q + TOW'(1);
                    end
                end
            end
            ST_OPEN: begin
                if (clr) state_d = ST_IDLE;
            end
            ST_LOCK: begin
                if (lock_q == LKW'(LOCK_CYC - 1)) begin
                    state_d    = ST_IDLE;
                    fail_cnt_d = '0;
                    lock_d     = '0;
                end else begin
                    lock_d = lock_q + LKW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the internal state, so they lag the deciding edge by one cycle.
    always_comb begin
        pass_en_d      = (state_q == ST_OPEN);
        locked_d       = (state_q == ST_LOCK);
        fail_pulse_d   = fail_hit_q;
        fail_cnt_out_d = fail_cnt_q;
    end

    always_ff @(posedge clkin or posedge reset) begin
        // NOTE: state registers take non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            mismatch_q     <= 1'b0;
            fail_cnt_q     <= '0;
            idle_q         <= '0;
            lock_q         <= '0;
            fail_hit_q     <= 1'b0;
            btn_q          <= '0;
            pass_en_q      <= 1'b0;
            locked_q       <= 1'b0;
            fail_pulse_q   <= 1'b0;
            fail_cnt_out_q <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            mismatch_q     <= mismatch_d;
            fail_cnt_q     <= fail_cnt_d;
            idle_q         <= idle_d;
            lock_q         <= lock_d;
            fail_hit_q     <= fail_hit_d;
            btn_q          <= btn_d;
            pass_en_q      <= pass_en_d;
            locked_q       <= locked_d;
            fail_pulse_q   <= fail_pulse_d;
            fail_cnt_out_q <= fail_cnt_out_d;
        end
    end

    assign pass_en    = pass_en_q;
    assign locked     = locked_q;
    assign fail_pulse = fail_pulse_q;
    assign fail_cnt   = fail_cnt_out_q;

endmodule

// File: tb/tb_pw_seq_checker.sv
// Self-checking bench for pw_seq_checker: directed scenarios plus $urandom traffic,
// every cycle compared against a behavioural model built from digit queues and cycle counts.
module tb_pw_seq_checker;

    localparam int NBTN        = 4;
    localparam int SEQ_LEN     = 4;
    localparam int MAX_FAIL    = 3;
    localparam int LOCK_CYC    = 1000;
    localparam int TIMEOUT_CYC = 500;
    localparam logic [7:0] PW_DEFAULT = 8'hE4;

    logic       clkin = 1'b0;
    logic       reset;
    logic [3:0] btn;
    logic       clr;
    logic       pw_load;
    logic [7:0] pw_new;
    logic       pass_en;
    logic       fail_pulse;
    logic       locked;
    logic [1:0] fail_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clkin = ~clkin;

    pw_seq_checker #(
        .NBTN(NBTN), .SEQ_LEN(SEQ_LEN), .PW_DEFAULT(PW_DEFAULT),
        .MAX_FAIL(MAX_FAIL), .LOCK_CYC(LOCK_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clkin(clkin), .reset(reset), .btn(btn), .clr(clr),
        .pw_load(pw_load), .pw_new(pw_new),
        .pass_en(pass_en), .fail_pulse(fail_pulse), .locked(locked), .fail_cnt(fail_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase, collected digits (-1 = invalid), attempt and cycle counts.
    typedef enum {M_IDLE, M_ENTRY, M_OPEN, M_LOCK} mphase_e;
    mphase_e    m_phase;
    int         m_digits[$];
    int         m_fails, m_idle, m_lock;
    bit         m_fail_now;
    logic [3:0] m_prev;
    logic [7:0] m_code;
    bit         e_pass, e_locked, e_fpulse;
    int         e_cnt;

    task automatic model_reset();
        m_phase = M_IDLE;
        m_digits.delete();
        m_fails = 0; m_idle = 0; m_lock = 0;
        m_fail_now = 0;
        m_prev = '0;
        m_code = PW_DEFAULT;
    endtask

    task automatic model_step();
        logic [3:0] rise;
        int nrise, d;
        bit ok;
        rise = btn & ~m_prev;
        m_prev = btn;
        // Outputs seen after this edge show what was decided at the previous one.
        e_pass = (m_phase == M_OPEN);
        e_locked = (m_phase == M_LOCK);
        e_fpulse = m_fail_now;
        e_cnt = m_fails;
        m_fail_now = 0;
        nrise = 0; d = -1;
        for (int i = 0; i < NBTN; i++) if (rise[i]) begin nrise++; d = i; end
        case (m_phase)
            M_IDLE, M_ENTRY: begin
                if (nrise > 0) begin
                    m_digits.push_back(nrise == 1 ? d : -1);
                    m_phase = M_ENTRY;
                    m_idle = 0;
                    if (m_digits.size() == SEQ_LEN) begin
                        ok = 1;
                        for (int k = 0; k < SEQ_LEN; k++)
                            if (m_digits[k] != int'(m_code[2*k +: 2])) ok = 0;
                        m_digits.delete();
                        if (ok) begin
                            m_phase = M_OPEN;
                            m_fails = 0;
                        end else begin
                            m_fail_now = 1;
                            m_fails++;
                            if (m_fails >= MAX_FAIL) begin m_phase = M_LOCK; m_lock = 0; end
                            else m_phase = M_IDLE;
                        end
                    end
                end else if (m_phase == M_ENTRY) begin
                    m_idle++;
                    if (m_idle >= TIMEOUT_CYC) begin
                        m_phase = M_IDLE;
                        m_digits.delete();
                        m_idle = 0;
                    end
                end
            end
            M_OPEN: begin
`ifdef PW_PROG_EN
                if (pw_load) m_code = pw_new;
`endif
                if (clr) m_phase = M_IDLE;
            end
            M_LOCK: begin
                m_lock++;
                if (m_lock >= LOCK_CYC) begin m_phase = M_IDLE; m_fails = 0; end
            end
            default: m_phase = M_IDLE;
        endcase
    endtask

    // One clock: drive at the falling edge, model at the rising edge, compare at the next falling edge.
    task automatic tick(input logic [3:0] b, input logic c = 1'b0,
                        input logic l = 1'b0, input logic [7:0] nw = 8'h00);
        btn = b; clr = c; pw_load = l; pw_new = nw;
        @(posedge clkin);
        model_step();
        @(negedge clkin);
        check("pass_en", pass_en, e_pass);
        check("fail_pulse", fail_pulse, e_fpulse);
        check("locked", locked, e_locked);
        check("fail_cnt", fail_cnt, e_cnt);
    endtask

    task automatic press(input int d);
        tick(4'b0001 << d);
        tick(4'b0000);
    endtask

    task automatic enter(input int a, input int b, input int c, input int d);
        press(a); press(b); press(c); press(d);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(4'b0000);
    endtask

    task automatic do_reset();
        btn = '0; clr = 1'b0; pw_load = 1'b0; pw_new = '0;
        reset = 1'b1;
        #1;
        check("rst_pass_en", pass_en, 0);
        check("rst_fail_pulse", fail_pulse, 0);
        check("rst_locked", locked, 0);
        check("rst_fail_cnt", fail_cnt, 0);
        @(posedge clkin);
        @(negedge clkin);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [3:0] b;
        int r;
        do_reset();

        enter(0, 1, 2, 3);
        check("open_after_code", pass_en, 1);
        check("open_fail_cnt", fail_cnt, 0);
        tick(4'b0000, 1'b1);
        idle(2);

        enter(0, 1, 3, 3);
        check("wrong_pulse", fail_pulse, 1);
        check("wrong_cnt", fail_cnt, 1);
        check("wrong_not_open", pass_en, 0);
        idle(1);
        check("pulse_one_cycle", fail_pulse, 0);
        enter(0, 1, 2, 3);
        check("reopen", pass_en, 1);
        check("reopen_cnt", fail_cnt, 0);
        tick(4'b0000, 1'b1);
        idle(2);

        enter(1, 1, 1, 1);
        enter(2, 2, 2, 2);
        enter(3, 0, 1, 2);
        check("lock_set", locked, 1);
        enter(0, 1, 2, 3);
        check("lock_ignores_code", pass_en, 0);
        idle(LOCK_CYC);
        check("lock_clear", locked, 0);
        check("lock_cnt_clear", fail_cnt, 0);
        enter(0, 1, 2, 3);
        check("open_after_lock", pass_en, 1);
        tick(4'b0000, 1'b1);
        idle(2);

        press(0); press(1);
        idle(TIMEOUT_CYC);
        check("timeout_no_pulse", fail_pulse, 0);
        enter(0, 1, 2, 3);
        check("open_after_timeout", pass_en, 1);
        tick(4'b0000, 1'b1);
        idle(2);

        tick(4'b0011); tick(4'b0000);
        press(1); press(2); press(3);
        check("multi_rise_fails", fail_pulse, 1);
        enter(0, 1, 2, 3);
        tick(4'b0000, 1'b1);
        tick(4'b0000);
        check("clr_closes", pass_en, 0);
        tick(4'b0000, 1'b1);
        idle(2);

        enter(0, 1, 2, 3);
        tick(4'b0000, 1'b1, 1'b1, 8'h1B);
        idle(2);
        enter(3, 2, 1, 0);
        tick(4'b0000, 1'b1);
        idle(2);
        enter(0, 1, 2, 3);
        tick(4'b0000, 1'b1);
        idle(2);

        do_reset();
        repeat (4000) begin
            r = $urandom_range(0, 99);
            if (r < 40)      b = 4'b0000;
            else if (r < 75) b = 4'b0001 << m_code[2*m_digits.size() +: 2];
            else if (r < 90) b = 4'b0001 << $urandom_range(0, 3);
            else             b = 4'($urandom_range(0, 15));
            tick(b, ($urandom_range(0, 19) == 0), ($urandom_range(0, 29) == 0), 8'($urandom));
            if ($urandom_range(0, 399) == 0) idle(TIMEOUT_CYC + 5);
        end

        do_reset();
        enter(1, 1, 1, 1);
        press(0); press(1);
        do_reset();
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
